load_store_unit: RTL and testbench

Memory-access stage of the RISC-V core, placed directly upstream of the byte-addressed, word-wide data RAM. It takes one load or store request at a time from the execute stage and decodes funct3 (byte/half/word, signed/unsigned). It drives the RAM's write-enable, address and write-data inputs and returns a sign- or zero-extended load result. Because the RAM always writes four bytes, SB/SH are done as a read-modify-write; misaligned and illegal accesses are rejected without touching memory.

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: decodes RISC-V loads/stores onto a word-wide, byte-addressed RAM.
// Sub-word stores are done as read-modify-write; misaligned or illegal requests fault without touching memory.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_fault,
  output logic                     mem_WE,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [2:0]               funct3_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    merge_q;

  logic                     req_fault;
  logic [7:0]               byte_lane;
  logic [15:0]              half_lane;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     word_store;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      F3_B:    req_fault = 1'b0;
      F3_H:    req_fault = req_addr[0];
      F3_W:    req_fault = |req_addr[1:0];
      F3_BU:   req_fault = req_we;
      F3_HU:   req_fault = req_we | req_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // Lane selection uses only the low address bits; the RAM word is little-endian.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_lane = mem_RD[7:0];
      2'd1: byte_lane = mem_RD[15:8];
      2'd2: byte_lane = mem_RD[23:16];
      2'd3: byte_lane = mem_RD[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

    load_data = '0;
    case (funct3_q)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data = mem_RD;
      F3_BU:   load_data = {24'h000000, byte_lane};
      F3_HU:   load_data = {16'h0000, half_lane};
      default: load_data = '0;
    endcase

    merged = mem_RD;
    if (funct3_q == F3_B) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign word_store = we_q && (funct3_q == F3_W);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_addr   = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_WE     = ((state == ACCESS) && word_store) || (state == WRITE);
  assign mem_WD     = (state == WRITE) ? merge_q :
                      ((state == ACCESS) && word_store) ? wdata_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            if (req_fault) begin
              resp_rdata <= '0;
              resp_fault <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            resp_rdata <= load_data;
            resp_fault <= 1'b0;
            state      <= RESP;
          end else if (word_store) begin
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            state      <= RESP;
          end else begin
            merge_q <= merged;
            state   <= WRITE;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small byte-addressed, word-wide RAM model.
// Expected values are hand-computed constants; latency and write-enable timing are tracked per request.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_WE;
  logic [31:0] mem_addr;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] ram [0:63];

  int tests = 0;
  int fails = 0;

  int          r_lat;
  int          r_we_mask;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [31:0] r_wd;
  logic [31:0] r_maddr;
  int          stray;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_WE     (mem_WE),
    .mem_addr   (mem_addr),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_WE) ram[mem_addr[7:2]] <= mem_WD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in IDLE and follows it to its response (bounded), then back to IDLE.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    r_lat = 0; r_we_mask = 0; r_wd = '0; r_maddr = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    if (mem_WE) r_we_mask |= 1;
    step();
    req_valid = 1'b0;
    r_lat = 1;
    r_maddr = mem_addr;
    while (!resp_valid && r_lat < 10) begin
      if (mem_WE) begin
        r_we_mask |= (1 << r_lat);
        r_wd = mem_WD;
      end
      step();
      r_lat++;
    end
    if (mem_WE) r_we_mask |= (1 << r_lat);
    r_rdata = resp_rdata;
    r_fault = resp_fault;
    step();
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
    run_req(1'b0, f3, addr, 32'h0);
    check({tag, " data"}, r_rdata, exp);
    check({tag, " latency"}, r_lat, 32'd2);
    check({tag, " fault"}, {31'b0, r_fault}, 32'd0);
    check({tag, " we"}, r_we_mask, 32'd0);
  endtask

  task automatic expect_fault(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
    run_req(we, f3, addr, 32'hFFFF_FFFF);
    check({tag, " fault"}, {31'b0, r_fault}, 32'd1);
    check({tag, " data"}, r_rdata, 32'd0);
    check({tag, " latency"}, r_lat, 32'd1);
    check({tag, " we"}, r_we_mask, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4]  = 32'h8899_AABB;
    ram[8]  = 32'h1122_3344;
    ram[16] = 32'hCAFE_F00D;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    check("reset req_ready",  {31'b0, req_ready},  32'd1);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata,          32'd0);
    check("reset resp_fault", {31'b0, resp_fault}, 32'd0);
    check("reset mem_WE",     {31'b0, mem_WE},     32'd0);
    check("reset mem_addr",   mem_addr,            32'd0);
    check("reset mem_WD",     mem_WD,              32'd0);

    // Loads from word 0x10 = 0x8899AABB
    load("LW 0x10", 3'd2, 32'h10, 32'h8899_AABB);
    check("LW hold data", resp_rdata, 32'h8899_AABB);
    check("LW hold valid", {31'b0, resp_valid}, 32'd0);
    load("LB 0x13",  3'd0, 32'h13, 32'hFFFF_FF88);
    check("LB 0x13 mem_addr aligned", r_maddr, 32'h10);
    load("LBU 0x13", 3'd4, 32'h13, 32'h0000_0088);
    load("LH 0x12",  3'd1, 32'h12, 32'hFFFF_8899);
    load("LHU 0x10", 3'd5, 32'h10, 32'h0000_AABB);
    load("LB 0x10",  3'd0, 32'h10, 32'hFFFF_FFBB);
    load("LBU 0x11", 3'd4, 32'h11, 32'h0000_00AA);

    // Sub-word stores as read-modify-write on word 0x20 = 0x11223344
    run_req(1'b1, 3'd0, 32'h21, 32'hFFFF_FFA5);
    check("SB 0x21 latency", r_lat, 32'd3);
    check("SB 0x21 we cycle", r_we_mask, 32'd4);
    check("SB 0x21 mem_WD", r_wd, 32'h1122_A544);
    check("SB 0x21 fault", {31'b0, r_fault}, 32'd0);
    check("SB 0x21 rdata", r_rdata, 32'd0);
    load("LW 0x20 after SB", 3'd2, 32'h20, 32'h1122_A544);
    run_req(1'b1, 3'd1, 32'h22, 32'h1234_BEEF);
    check("SH 0x22 we cycle", r_we_mask, 32'd4);
    check("SH 0x22 mem_WD", r_wd, 32'hBEEF_A544);
    load("LW 0x20 after SH", 3'd2, 32'h20, 32'hBEEF_A544);

    // Faulting requests
    expect_fault("SH 0x23", 1'b1, 3'd1, 32'h23);
    expect_fault("LW 0x22", 1'b0, 3'd2, 32'h22);
    expect_fault("f3=3 load", 1'b0, 3'd3, 32'h10);
    expect_fault("store f3=4", 1'b1, 3'd4, 32'h10);
    load("LW 0x20 after faults", 3'd2, 32'h20, 32'hBEEF_A544);

    // Back-to-back with req_valid held high: SW then LW
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    step();
    check("b2b T+1 req_ready", {31'b0, req_ready}, 32'd0);
    check("b2b T+1 mem_WE", {31'b0, mem_WE}, 32'd1);
    check("b2b T+1 mem_WD", mem_WD, 32'hDEAD_BEEF);
    step();
    check("b2b T+2 resp_valid", {31'b0, resp_valid}, 32'd1);
    req_we = 1'b0; req_wdata = 32'h0;
    step();
    check("b2b T+3 req_ready", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("b2b T+4 req_ready", {31'b0, req_ready}, 32'd0);
    check("b2b T+4 resp_valid", {31'b0, resp_valid}, 32'd0);
    step();
    check("b2b T+5 resp_valid", {31'b0, resp_valid}, 32'd1);
    check("b2b T+5 rdata", resp_rdata, 32'hDEAD_BEEF);
    step();

    // Reset during the read cycle of an SB aborts it without writing
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h40; req_wdata = 32'h0000_0055;
    step();
    req_valid = 1'b0;
    check("rst SB read cycle mem_WE", {31'b0, mem_WE}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst async req_ready", {31'b0, req_ready}, 32'd1);
    check("rst async mem_WE", {31'b0, mem_WE}, 32'd0);
    stray = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (mem_WE || resp_valid) stray++;
      step();
    end
    check("rst no stray WE/resp", stray, 32'd0);
    check("rst req_ready after release", {31'b0, req_ready}, 32'd1);
    load("LW 0x40 unchanged", 3'd2, 32'h40, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
